// File: rtl/alu_regfile_wb_if.sv
// Bus between the ALU-side control logic and the register file / writeback stage.
// The master drives read addresses and the executing instruction's result; the slave returns operands.
interface alu_regfile_wb_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              carry_flag;
    logic              zero_flag;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_dest;
    logic              ex_wr_en;
    logic              ex_flag_we;
    logic [DATA_W-1:0] alu_out;
    logic              alu_cout;
    logic              alu_zero;
    logic              stall;
    logic              flush;
    logic              wb_busy;

    modport master (
        output rd_addr_a, rd_addr_b, ex_valid, ex_dest, ex_wr_en, ex_flag_we,
        output alu_out, alu_cout, alu_zero, stall, flush,
        input  rd_data_a, rd_data_b, carry_flag, zero_flag, wb_busy
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, ex_valid, ex_dest, ex_wr_en, ex_flag_we,
        input  alu_out, alu_cout, alu_zero, stall, flush,
        output rd_data_a, rd_data_b, carry_flag, zero_flag, wb_busy
    );
endinterface

// File: rtl/alu_regfile_wb.sv
// Register file with a one-entry writeback register and registered forwarding.
// Flags bypass the writeback register so a following ADDC sees the new carry.
module alu_regfile_wb #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4
) (
    input logic             clk,
    input logic             rst_n,
    alu_regfile_wb_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              capture;
    logic              flag_upd;

    assign capture  = bus.ex_valid & bus.ex_wr_en & ~bus.stall & ~bus.flush;
    assign flag_upd = bus.ex_valid & bus.ex_flag_we & ~bus.stall & ~bus.flush;

    always_comb begin
        regs_d = regs_q;
        // Out-of-range destinations match no entry, so their commit is dropped.
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wb_valid_q && (wb_dest_q == ADDR_W'(i))) begin
                regs_d[i] = wb_data_q;
            end
        end

        wb_valid_d = capture;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        if (capture) begin
            wb_dest_d = bus.ex_dest;
            wb_data_d = bus.alu_out;
        end

        carry_d = carry_q;
        zero_d  = zero_q;
        if (flag_upd) begin
            carry_d = bus.alu_cout;
            zero_d  = bus.alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
        end
    end

    // Reads see only registered state, never alu_out, so no loop through the ALU.
    always_comb begin
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr_a == ADDR_W'(i)) begin
                bus.rd_data_a = regs_q[i];
            end
            if (bus.rd_addr_b == ADDR_W'(i)) begin
                bus.rd_data_b = regs_q[i];
            end
        end
        if (wb_valid_q && (bus.rd_addr_a == wb_dest_q)) begin
            bus.rd_data_a = wb_data_q;
        end
        if (wb_valid_q && (bus.rd_addr_b == wb_dest_q)) begin
            bus.rd_data_b = wb_data_q;
        end
    end

    assign bus.carry_flag = carry_q;
    assign bus.zero_flag  = zero_q;
    assign bus.wb_busy    = wb_valid_q;

endmodule

// File: doc/alu_regfile_wb.md
Name: alu_regfile_wb

Overview:
- Register file and writeback stage around the 8-bit ALU.
- Upstream of the ALU: supplies operands a/b and carry-in.
- Downstream of the ALU: captures out/cout/zero into a one-entry writeback register, then commits to the array on the following edge.
- Registered forwarding keeps back-to-back dependent instructions correct without a combinational path from ALU output to ALU input.

Parameters:
- DATA_W, 8, register and ALU data width.
- NUM_REGS, 16, number of architectural registers.
- ADDR_W, 4, register address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_a  in  ADDR_W  source register for ALU operand a.
- rd_addr_b  in  ADDR_W  source register for ALU operand b.
- rd_data_a  out  DATA_W  operand a to ALU (combinational from state).
- rd_data_b  out  DATA_W  operand b to ALU (combinational from state).
- carry_flag  out  1  architectural carry, drives ALU cin.
- zero_flag  out  1  architectural zero flag.
- ex_valid  in  1  ALU result this cycle belongs to a real instruction.
- ex_dest  in  ADDR_W  destination register of current ALU result.
- ex_wr_en  in  1  instruction writes a register.
- ex_flag_we  in  1  instruction updates carry/zero.
- alu_out  in  DATA_W  ALU out.
- alu_cout  in  1  ALU cout.
- alu_zero  in  1  ALU zero.
- stall  in  1  hold: do not capture the current ALU result.
- flush  in  1  discard the current ALU result.
- wb_busy  out  1  writeback register holds an uncommitted write.

Behaviour:
- Reset (async, rst_n low): all registers 0; wb_valid 0; wb_dest 0; wb_data 0; carry_flag 0; zero_flag 0. Outputs go to reset values immediately, without waiting for clk. Release is synchronous to the next edge.
- capture = ex_valid & ex_wr_en & ~stall & ~flush.
- flag_upd = ex_valid & ex_flag_we & ~stall & ~flush.
- Each edge, commit: if wb_valid, write regs[wb_dest] <= wb_data.
- Each edge, capture:
  - if capture: wb_valid <= 1, wb_dest <= ex_dest, wb_data <= alu_out;
  - else: wb_valid <= 0.
  - Commit and capture happen on the same edge (pipelined, no bubble).
- Flags: if flag_upd, carry_flag <= alu_cout and zero_flag <= alu_zero on that edge; otherwise both hold. Flags bypass the writeback register, so an ADDC in the very next cycle sees the new carry. Flags update independently of ex_wr_en.
- Reads (per port, combinational):
  - if wb_valid and address == wb_dest: wb_data (forward);
  - else: regs[address].
  - Reads never depend on alu_out, which prevents a combinational loop through the ALU.
- Latency:
  - Result visible to a dependent read 1 cycle after capture, via forwarding.
  - Result present in the array 2 cycles after capture.
- Stall: no capture and no flag update. A pending wb entry still commits and wb_valid clears, so the writeback register drains during a stall.
- Flush: same effect as stall for the current cycle's result and flags. If stall and flush are both high, flush semantics apply; the outcome is identical.
- Same dest twice back-to-back: the second capture overwrites the wb register on the same edge the first commits. Forwarding returns the newer value.
- Address >= NUM_REGS:
  - Reads return 0.
  - Captures to such an address are still accepted into the wb register. Forwarding to that address returns wb_data while wb_valid.
  - The commit to the array is dropped.
- wb_busy = wb_valid.
- Reset mid-operation: a pending wb entry is lost and flags clear.

Test Plan:
- Reset: write r3=0x5A, assert rst_n=0 between edges -> rd_data_a(r3)=0x00 and carry_flag=0 immediately.
- Forwarding: capture r2<=0x7F at edge N, read r2 in cycle N+1 -> 0x7F from wb; cycle N+2 -> 0x7F from array, wb_busy=0.
- Carry chain: ADD with alu_cout=1 and flag_we at edge N -> carry_flag=1 in cycle N+1. Next cycle, flag_upd with cout=0 -> carry_flag=0.
- Stall drain: capture r5<=0x11, then hold stall=1 with ex_valid=1 and alu_out=0xEE -> r5=0x11, wb_busy drops after 1 cycle, and 0xEE is never written.
- Flush: flush=1, ex_flag_we=1, alu_cout=1 -> carry_flag is unchanged and no register changes.
- Back-to-back: r1<=0x01 at edge N, r1<=0x02 at edge N+1 -> read r1 = 0x01 in cycle N+1 and 0x02 from cycle N+2 onward. Array r1 = 0x02 after edge N+2.
